// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package counter_pkg;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) w = i + 1;
    end
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/updown_prescaler.sv
// Enable-gated prescaler: emits one tick every PRESCALE enabled cycles.
module updown_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sync_rst,
  output logic tick
);

  localparam int unsigned PreW = clog2_min1(PRESCALE);
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;

  // Tick on the last enabled cycle of each prescale period; PRESCALE=1 gives tick = en.
  assign tick = en && (pre_q == PreMax);

  // Next prescaler value: sync reset wins, en=0 freezes progress.
  always_comb begin
    pre_d = pre_q;
    if (sync_rst) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PreW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with prescaler, load/clear, terminal count and wrap pulse.
// Optional sticky overflow flag on port ovf_sticky when UDC_STICKY_OVF_EN is defined.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         wrap
`ifdef UDC_STICKY_OVF_EN
  ,
  output logic         ovf_sticky
`endif
);

  localparam logic [N-1:0] MaxVal = N'(MODULUS - 1);
  // Extra bit so MODULUS = 2**N is representable in the clamp compare.
  localparam logic [N:0]   ModExt = (N + 1)'(MODULUS);

  logic [N-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         tick;
  logic         at_end;

  updown_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .sync_rst(clear | load),
    .tick    (tick)
  );

  // Range end in the current direction; doubles as the terminal-count output.
  assign at_end = (up_dn == UP) ? (count_q == MaxVal) : (count_q == '0);
  assign tc     = at_end;
  assign count  = count_q;
  assign wrap   = wrap_q;

  // Next count and wrap: clear > load > step > hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_val} >= ModExt) ? MaxVal : load_val;
    end else if (tick) begin
      if (!at_end) begin
        count_d = (up_dn == UP) ? count_q + N'(1) : count_q - N'(1);
      end else if (SATURATE == 0) begin
        count_d = (up_dn == UP) ? '0 : MaxVal;
        wrap_d  = 1'b1;
      end
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef UDC_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Any step taken at a range end (wrapping or held) sets the flag; only clear drops it.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (!load && tick && at_end) begin
      ovf_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: three counters (wrap, saturate, prescale-by-3), MODULUS=10, N=4.
module tb_updown_mod_counter;

  logic       clk;
  logic       reset_n;
  logic       en_s  [3];
  logic       ud_s  [3];
  logic       ld_s  [3];
  logic [3:0] lv_s  [3];
  logic       cl_s  [3];
  logic [3:0] cnt_s [3];
  logic       tc_s  [3];
  logic       wr_s  [3];
`ifdef UDC_STICKY_OVF_EN
  logic       ovf_s [3];
`endif

  typedef struct {
    int         id;
    string      nm;
    logic [3:0] cnt;
    logic       tc;
    logic       wr;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  updown_mod_counter #(.N(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en_s[0]), .up_dn(ud_s[0]), .load(ld_s[0]),
    .load_val(lv_s[0]), .clear(cl_s[0]), .count(cnt_s[0]), .tc(tc_s[0]), .wrap(wr_s[0])
`ifdef UDC_STICKY_OVF_EN
    , .ovf_sticky(ovf_s[0])
`endif
  );

  updown_mod_counter #(.N(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en_s[1]), .up_dn(ud_s[1]), .load(ld_s[1]),
    .load_val(lv_s[1]), .clear(cl_s[1]), .count(cnt_s[1]), .tc(tc_s[1]), .wrap(wr_s[1])
`ifdef UDC_STICKY_OVF_EN
    , .ovf_sticky(ovf_s[1])
`endif
  );

  updown_mod_counter #(.N(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut_p (
    .clk(clk), .reset_n(reset_n), .en(en_s[2]), .up_dn(ud_s[2]), .load(ld_s[2]),
    .load_val(lv_s[2]), .clear(cl_s[2]), .count(cnt_s[2]), .tc(tc_s[2]), .wrap(wr_s[2])
`ifdef UDC_STICKY_OVF_EN
    , .ovf_sticky(ovf_s[2])
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus on DUT d (others idle) and queue the post-edge expectation.
  task automatic cyc(input int d, input string nm, input logic e, input logic ud,
                     input logic ld, input logic [3:0] lv, input logic cl,
                     input logic [3:0] xc, input logic xt, input logic xw, input logic xo);
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      en_s[i] = 1'b0;
      ld_s[i] = 1'b0;
      cl_s[i] = 1'b0;
    end
    en_s[d] = e;
    ud_s[d] = ud;
    ld_s[d] = ld;
    lv_s[d] = lv;
    cl_s[d] = cl;
    x.id = d; x.nm = nm; x.cnt = xc; x.tc = xt; x.wr = xw; x.ovf = xo;
    q.push_back(x);
  endtask

  // Monitor: after each rising edge, pop the pending expectation and compare.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check({mon_e.nm, ".count"}, 32'(cnt_s[mon_e.id]), 32'(mon_e.cnt));
      check({mon_e.nm, ".tc"}, 32'(tc_s[mon_e.id]), 32'(mon_e.tc));
      check({mon_e.nm, ".wrap"}, 32'(wr_s[mon_e.id]), 32'(mon_e.wr));
`ifdef UDC_STICKY_OVF_EN
      if (mon_e.id == 1) check({mon_e.nm, ".ovf"}, 32'(ovf_s[1]), 32'(mon_e.ovf));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_s[i] = 1'b0; ud_s[i] = 1'b0; ld_s[i] = 1'b0; lv_s[i] = 4'd0; cl_s[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d.count", i), 32'(cnt_s[i]), 32'd0);
      check($sformatf("rst%0d.wrap", i), 32'(wr_s[i]), 32'd0);
      check($sformatf("rst%0d.tc", i), 32'(tc_s[i]), 32'd1);
    end
    reset_n = 1'b1;

    // 1: count up through the wrap.
    for (int k = 1; k <= 12; k++) begin
      c = 4'(k % 10);
      cyc(0, $sformatf("up%0d", k), 1, 1, 0, 0, 0, c, c == 4'd9, k == 10, 0);
    end

    // 2: clear, then count down through the wrap.
    cyc(0, "clr", 0, 0, 0, 0, 1, 4'd0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      c = 4'((10 - (k % 10)) % 10);
      cyc(0, $sformatf("dn%0d", k), 1, 0, 0, 0, 0, c, c == 4'd0, (k % 10) == 1, 0);
    end

    // 3: saturating variant holds at both ends.
    for (int k = 1; k <= 12; k++) begin
      c = (k > 9) ? 4'd9 : 4'(k);
      cyc(1, $sformatf("sat_up%0d", k), 1, 1, 0, 0, 0, c, c == 4'd9, 0, k >= 10);
    end
    cyc(1, "sat_clr", 0, 0, 0, 0, 1, 4'd0, 1, 0, 0);
    cyc(1, "sat_dn1", 1, 0, 0, 0, 0, 4'd0, 1, 0, 1);
    cyc(1, "sat_dn2", 1, 0, 0, 0, 0, 4'd0, 1, 0, 1);

    // 4: load clamp and priorities.
    cyc(0, "ld13",   0, 1, 1, 4'd13, 0, 4'd9, 1, 0, 0);
    cyc(0, "ldclr",  0, 1, 1, 4'd13, 1, 4'd0, 0, 0, 0);
    cyc(0, "ld4en",  1, 1, 1, 4'd4,  0, 4'd4, 0, 0, 0);
    cyc(0, "ld_up",  1, 1, 0, 4'd0,  0, 4'd5, 0, 0, 0);
    cyc(0, "ld10",   0, 1, 1, 4'd10, 0, 4'd9, 1, 0, 0);
    cyc(0, "ld1",    0, 1, 1, 4'd1,  0, 4'd1, 0, 0, 0);
    cyc(0, "ld9",    0, 1, 1, 4'd9,  0, 4'd9, 1, 0, 0);
    cyc(0, "ld_wrap", 1, 1, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    cyc(0, "ld3dn",  1, 0, 1, 4'd3,  0, 4'd3, 0, 0, 0);
    cyc(0, "clr_en", 1, 1, 0, 4'd0,  1, 4'd0, 0, 0, 0);

    // 5: prescale by 3 with en gaps, load restart, direction change mid-period.
    cyc(2, "p1", 1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(2, "p2", 1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(2, "p3", 0, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(2, "p4", 1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    cyc(2, "p5", 1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    cyc(2, "p6", 1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    cyc(2, "p7", 1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
    cyc(2, "p8", 1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
    cyc(2, "p9", 1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
    cyc(2, "p_ld5", 1, 1, 1, 4'd5, 0, 4'd5, 0, 0, 0);
    cyc(2, "p10", 1, 1, 0, 0, 0, 4'd5, 0, 0, 0);
    cyc(2, "p11", 1, 1, 0, 0, 0, 4'd5, 0, 0, 0);
    cyc(2, "p12", 1, 1, 0, 0, 0, 4'd6, 0, 0, 0);
    cyc(2, "p13", 1, 1, 0, 0, 0, 4'd6, 0, 0, 0);
    cyc(2, "p14", 1, 1, 0, 0, 0, 4'd6, 0, 0, 0);
    cyc(2, "p_dn", 1, 0, 0, 0, 0, 4'd5, 0, 0, 0);

    // 6: asynchronous reset between edges discards count and prescaler progress.
    cyc(0, "ld7",  0, 1, 1, 4'd7, 0, 4'd7, 0, 0, 0);
    cyc(2, "p_pre", 1, 1, 0, 0, 0, 4'd5, 0, 0, 0);
    @(posedge clk);
    #3;
    for (int i = 0; i < 3; i++) en_s[i] = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst.count", 32'(cnt_s[0]), 32'd0);
    check("arst.wrap", 32'(wr_s[0]), 32'd0);
    check("arst_p.count", 32'(cnt_s[2]), 32'd0);
`ifdef UDC_STICKY_OVF_EN
    check("arst.ovf", 32'(ovf_s[1]), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, "rs_up1", 1, 1, 0, 0, 0, 4'd1, 0, 0, 0);
    cyc(0, "rs_up2", 1, 1, 0, 0, 0, 4'd2, 0, 0, 0);
    cyc(2, "rs_p1", 1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(2, "rs_p2", 1, 1, 0, 0, 0, 4'd0, 0, 0, 0);
    cyc(2, "rs_p3", 1, 1, 0, 0, 0, 4'd1, 0, 0, 0);

    @(posedge clk);
    #4;
    check("drain.qsize", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
